ibex_register_file_banked: RTL and testbench

Flip-flop register file with `NumBanks` architectural register banks and a background context spill/fill engine for fast interrupt and context switching in the rt-ibex core. The core always reads and writes the active bank. A command port switches the active bank in one cycle, or streams registers x1..x`CxNumRegs` of an inactive bank out to memory or back in over valid/ready word ports. It replaces the single-bank file at the same place in the ID/WB stages.

---
 rtl/ibex_register_file_banked_pkg.sv | 18 +
 rtl/ibex_register_file_banked_rf_bank.sv | 50 +++++
 rtl/ibex_register_file_banked.sv | 177 +++++++++++++++++
 tb/tb_ibex_register_file_banked.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_register_file_banked_pkg.sv
// Shared types for the banked register file: context-engine opcodes,
// engine index width and engine FSM state encodings.
package ibex_register_file_banked_pkg;

    typedef enum logic [1:0] {
        CX_SWITCH = 2'd0,
        CX_SPILL  = 2'd1,
        CX_FILL   = 2'd2,
        CX_RSVD   = 2'd3
    } cx_op_e;

    localparam int unsigned IBEX_CX_IDX_W = 4;

    localparam logic [1:0] CX_ST_IDLE  = 2'd0;
    localparam logic [1:0] CX_ST_SPILL = 2'd1;
    localparam logic [1:0] CX_ST_FILL  = 2'd2;

endpackage

// File: rtl/ibex_register_file_banked_rf_bank.sv
// One architectural register bank: flop-based x1..xN with x0 hardwired,
// two core read ports, a core write port and an engine read/write port.
module ibex_register_file_banked_rf_bank #(
    parameter int unsigned          NumRegs     = 32,
    parameter int unsigned          AddrW       = 5,
    parameter int unsigned          DataWidth   = 32,
    parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrW-1:0]     i_raddrA,
    input  logic [AddrW-1:0]     i_raddrB,
    output logic [DataWidth-1:0] o_rdataA,
    output logic [DataWidth-1:0] o_rdataB,
    input  logic                 i_coreWe,
    input  logic [AddrW-1:0]     i_coreWaddr,
    input  logic [DataWidth-1:0] i_coreWdata,
    input  logic                 i_engWe,
    input  logic [AddrW-1:0]     i_engAddr,
    input  logic [DataWidth-1:0] i_engWdata,
    output logic [DataWidth-1:0] o_engRdata
);

    logic [DataWidth-1:0] w_regs [NumRegs];

    assign w_regs[0] = WordZeroVal;

    // The top level never targets the same bank from both ports, so the
    // ordering of the two write enables below only matters defensively.
    for (genvar i = 1; i < NumRegs; i++) begin : g_reg
        logic [DataWidth-1:0] r_word;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_word <= WordZeroVal;
            end else if (i_coreWe && (i_coreWaddr == AddrW'(i))) begin
                r_word <= i_coreWdata;
            end else if (i_engWe && (i_engAddr == AddrW'(i))) begin
                r_word <= i_engWdata;
            end
        end

        assign w_regs[i] = r_word;
    end

    assign o_rdataA   = w_regs[i_raddrA];
    assign o_rdataB   = w_regs[i_raddrB];
    assign o_engRdata = w_regs[i_engAddr];

endmodule

// File: rtl/ibex_register_file_banked.sv
// Multi-bank register file with a background spill/fill engine; the core
// always sees the active bank while the engine streams an inactive one.
module ibex_register_file_banked
    import ibex_register_file_banked_pkg::*;
#(
    parameter bit                   RV32E       = 1'b0,
    parameter int unsigned          DataWidth   = 32,
    parameter int unsigned          NumBanks    = 2,
    parameter int unsigned          CxNumRegs   = 15,
    parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     test_en_i,
    input  logic [4:0]               raddr_a_i,
    output logic [DataWidth-1:0]     rdata_a_o,
    input  logic [4:0]               raddr_b_i,
    output logic [DataWidth-1:0]     rdata_b_o,
    input  logic [4:0]               waddr_a_i,
    input  logic [DataWidth-1:0]     wdata_a_i,
    input  logic                     we_a_i,
    input  logic                     cx_cmd_valid_i,
    output logic                     cx_cmd_ready_o,
    input  logic [1:0]               cx_cmd_op_i,
    input  logic [1:0]               cx_cmd_bank_i,
    output logic                     cx_spill_valid_o,
    input  logic                     cx_spill_ready_i,
    output logic [DataWidth-1:0]     cx_spill_data_o,
    output logic [IBEX_CX_IDX_W-1:0] cx_spill_idx_o,
    input  logic                     cx_fill_valid_i,
    output logic                     cx_fill_ready_o,
    input  logic [DataWidth-1:0]     cx_fill_data_i,
    output logic [1:0]               active_bank_o,
    output logic                     cx_done_o,
    output logic                     err_o
);

    localparam int unsigned NumRegs = RV32E ? 16 : 32;
    localparam int unsigned AddrW   = RV32E ? 4 : 5;

    logic [1:0]               r_state;
    logic [1:0]               r_activeBank;
    logic [1:0]               r_tgt;
    logic [IBEX_CX_IDX_W-1:0] r_idx;
    logic                     r_done;
    logic                     r_err;

    cx_op_e               w_op;
    logic                 w_cmdAccept;
    logic                 w_illegal;
    logic                 w_xferHs;
    logic                 w_lastIdx;
    logic [AddrW-1:0]     w_engAddr;
    logic [DataWidth-1:0] w_engRdataSel;
    logic                 w_unused;

    logic [NumBanks-1:0]  w_coreWe;
    logic [NumBanks-1:0]  w_engWe;
    logic [DataWidth-1:0] w_rdataA   [NumBanks];
    logic [DataWidth-1:0] w_rdataB   [NumBanks];
    logic [DataWidth-1:0] w_engRdata [NumBanks];

    // Upper address bit is dead in RV32E; test_en_i has no function here.
    assign w_unused = test_en_i ^ raddr_a_i[4] ^ raddr_b_i[4] ^ waddr_a_i[4];

    assign w_op        = cx_op_e'(cx_cmd_op_i);
    assign w_cmdAccept = cx_cmd_valid_i && (r_state == CX_ST_IDLE);
    assign w_illegal   = (w_op == CX_RSVD)
                      || (int'(cx_cmd_bank_i) >= int'(NumBanks))
                      || ((w_op != CX_SWITCH) && (cx_cmd_bank_i == r_activeBank));
    assign w_xferHs    = ((r_state == CX_ST_SPILL) && cx_spill_ready_i)
                      || ((r_state == CX_ST_FILL) && cx_fill_valid_i);
    assign w_lastIdx   = (r_idx == IBEX_CX_IDX_W'(CxNumRegs));
    assign w_engAddr   = AddrW'(r_idx);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= CX_ST_IDLE;
            r_activeBank <= 2'd0;
            r_tgt        <= 2'd0;
            r_idx        <= IBEX_CX_IDX_W'(1);
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                CX_ST_IDLE: begin
                    if (w_cmdAccept) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end else begin
                            case (w_op)
                                CX_SWITCH: r_activeBank <= cx_cmd_bank_i;
                                CX_SPILL: begin
                                    r_tgt   <= cx_cmd_bank_i;
                                    r_idx   <= IBEX_CX_IDX_W'(1);
                                    r_state <= CX_ST_SPILL;
                                end
                                CX_FILL: begin
                                    r_tgt   <= cx_cmd_bank_i;
                                    r_idx   <= IBEX_CX_IDX_W'(1);
                                    r_state <= CX_ST_FILL;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                CX_ST_SPILL, CX_ST_FILL: begin
                    if (w_xferHs) begin
                        if (w_lastIdx) begin
                            r_state <= CX_ST_IDLE;
                            r_idx   <= IBEX_CX_IDX_W'(1);
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IBEX_CX_IDX_W'(1);
                        end
                    end
                end
                default: r_state <= CX_ST_IDLE;
            endcase
        end
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        assign w_coreWe[b] = we_a_i && (r_activeBank == 2'(b));
        assign w_engWe[b]  = (r_state == CX_ST_FILL) && cx_fill_valid_i
                          && (r_tgt == 2'(b));

        ibex_register_file_banked_rf_bank #(
            .NumRegs    (NumRegs),
            .AddrW      (AddrW),
            .DataWidth  (DataWidth),
            .WordZeroVal(WordZeroVal)
        ) u_bank (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .i_raddrA   (raddr_a_i[AddrW-1:0]),
            .i_raddrB   (raddr_b_i[AddrW-1:0]),
            .o_rdataA   (w_rdataA[b]),
            .o_rdataB   (w_rdataB[b]),
            .i_coreWe   (w_coreWe[b]),
            .i_coreWaddr(waddr_a_i[AddrW-1:0]),
            .i_coreWdata(wdata_a_i),
            .i_engWe    (w_engWe[b]),
            .i_engAddr  (w_engAddr),
            .i_engWdata (cx_fill_data_i),
            .o_engRdata (w_engRdata[b])
        );
    end

    always_comb begin
        rdata_a_o     = WordZeroVal;
        rdata_b_o     = WordZeroVal;
        w_engRdataSel = '0;
        for (int b = 0; b < NumBanks; b++) begin
            if (r_activeBank == 2'(b)) begin
                rdata_a_o = w_rdataA[b];
                rdata_b_o = w_rdataB[b];
            end
            if (r_tgt == 2'(b)) begin
                w_engRdataSel = w_engRdata[b];
            end
        end
    end

    assign cx_cmd_ready_o   = (r_state == CX_ST_IDLE);
    assign cx_spill_valid_o = (r_state == CX_ST_SPILL);
    assign cx_spill_data_o  = (r_state == CX_ST_SPILL) ? w_engRdataSel : '0;
    assign cx_spill_idx_o   = (r_state == CX_ST_IDLE) ? '0 : r_idx;
    assign cx_fill_ready_o  = (r_state == CX_ST_FILL);
    assign active_bank_o    = r_activeBank;
    assign cx_done_o        = r_done;
    assign err_o            = r_err;

endmodule

// File: tb/tb_ibex_register_file_banked.sv
// Directed bench for the banked register file: reset, bank isolation,
// spill with backpressure, fill alongside core writes, illegal commands, mid-transfer reset.
module tb_ibex_register_file_banked;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        test_en_i;
    logic [4:0]  raddr_a_i, raddr_b_i, waddr_a_i;
    logic [31:0] rdata_a_o, rdata_b_o, wdata_a_i;
    logic        we_a_i;
    logic        cx_cmd_valid_i, cx_cmd_ready_o;
    logic [1:0]  cx_cmd_op_i, cx_cmd_bank_i;
    logic        cx_spill_valid_o, cx_spill_ready_i;
    logic [31:0] cx_spill_data_o;
    logic [3:0]  cx_spill_idx_o;
    logic        cx_fill_valid_i, cx_fill_ready_o;
    logic [31:0] cx_fill_data_i;
    logic [1:0]  active_bank_o;
    logic        cx_done_o, err_o;

    int compared   = 0;
    int mismatched = 0;

    ibex_register_file_banked dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .test_en_i       (test_en_i),
        .raddr_a_i       (raddr_a_i),
        .rdata_a_o       (rdata_a_o),
        .raddr_b_i       (raddr_b_i),
        .rdata_b_o       (rdata_b_o),
        .waddr_a_i       (waddr_a_i),
        .wdata_a_i       (wdata_a_i),
        .we_a_i          (we_a_i),
        .cx_cmd_valid_i  (cx_cmd_valid_i),
        .cx_cmd_ready_o  (cx_cmd_ready_o),
        .cx_cmd_op_i     (cx_cmd_op_i),
        .cx_cmd_bank_i   (cx_cmd_bank_i),
        .cx_spill_valid_o(cx_spill_valid_o),
        .cx_spill_ready_i(cx_spill_ready_i),
        .cx_spill_data_o (cx_spill_data_o),
        .cx_spill_idx_o  (cx_spill_idx_o),
        .cx_fill_valid_i (cx_fill_valid_i),
        .cx_fill_ready_o (cx_fill_ready_o),
        .cx_fill_data_i  (cx_fill_data_i),
        .active_bank_o   (active_bank_o),
        .cx_done_o       (cx_done_o),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] bank);
        cx_cmd_valid_i = 1'b1;
        cx_cmd_op_i    = op;
        cx_cmd_bank_i  = bank;
        step();
        cx_cmd_valid_i = 1'b0;
    endtask

    task automatic writeReg(input logic [4:0] addr, input logic [31:0] data);
        we_a_i    = 1'b1;
        waddr_a_i = addr;
        wdata_a_i = data;
        step();
        we_a_i    = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [4:0] addr,
                             input logic [31:0] expected);
        raddr_a_i = addr;
        #1;
        checkOutput(tag, rdata_a_o, expected);
    endtask

    initial begin
        int expIdx;
        int k;
        rst_ni = 1'b0; test_en_i = 1'b0;
        raddr_a_i = 5'd0; raddr_b_i = 5'd0; waddr_a_i = 5'd0; wdata_a_i = '0; we_a_i = 1'b0;
        cx_cmd_valid_i = 1'b0; cx_cmd_op_i = 2'd0; cx_cmd_bank_i = 2'd0;
        cx_spill_ready_i = 1'b0; cx_fill_valid_i = 1'b0; cx_fill_data_i = '0;
        repeat (3) step();

        // Reset state
        checkOutput("rst_cmd_ready", cx_cmd_ready_o, 1);
        checkOutput("rst_spill_valid", cx_spill_valid_o, 0);
        checkOutput("rst_fill_ready", cx_fill_ready_o, 0);
        checkOutput("rst_done", cx_done_o, 0);
        checkOutput("rst_err", err_o, 0);
        checkOutput("rst_spill_data", cx_spill_data_o, 0);
        checkOutput("rst_spill_idx", cx_spill_idx_o, 0);
        checkOutput("rst_active", active_bank_o, 0);
        rst_ni = 1'b1;
        step();

        // Reset and read back
        writeReg(5'd5, 32'hDEADBEEF);
        raddr_b_i = 5'd0;
        readCheck("b0_x5", 5'd5, 32'hDEADBEEF);
        checkOutput("b0_x0", rdata_b_o, 32'h0);

        // Bank isolation
        applyStimulus(2'd0, 2'd1);
        checkOutput("switch1_active", active_bank_o, 1);
        checkOutput("switch1_err", err_o, 0);
        readCheck("b1_x5_init", 5'd5, 32'h0);
        writeReg(5'd5, 32'h1);
        readCheck("b1_x5_wr", 5'd5, 32'h1);
        applyStimulus(2'd0, 2'd0);
        checkOutput("switch0_active", active_bank_o, 0);
        readCheck("b0_x5_iso", 5'd5, 32'hDEADBEEF);

        // Spill with backpressure
        applyStimulus(2'd0, 2'd1);
        for (int i = 1; i <= 15; i++) writeReg(5'(i), 32'h100 + 32'(i));
        applyStimulus(2'd0, 2'd0);
        applyStimulus(2'd1, 2'd1);
        checkOutput("spill_ready_busy", cx_cmd_ready_o, 0);
        expIdx = 1;
        k = 0;
        while (expIdx <= 15 && k < 60) begin
            cx_spill_ready_i = (k % 2) == 1;
            checkOutput($sformatf("spill_valid_c%0d", k), cx_spill_valid_o, 1);
            checkOutput($sformatf("spill_idx_c%0d", k), cx_spill_idx_o, 32'(expIdx));
            checkOutput($sformatf("spill_data_c%0d", k), cx_spill_data_o, 32'h100 + 32'(expIdx));
            checkOutput($sformatf("spill_done_early_c%0d", k), cx_done_o, 0);
            if (cx_spill_ready_i) expIdx++;
            k++;
            step();
        end
        cx_spill_ready_i = 1'b0;
        checkOutput("spill_word_count", 32'(expIdx), 16);
        checkOutput("spill_done", cx_done_o, 1);
        checkOutput("spill_cmd_ready", cx_cmd_ready_o, 1);
        checkOutput("spill_valid_end", cx_spill_valid_o, 0);
        checkOutput("spill_idx_end", cx_spill_idx_o, 0);
        step();
        checkOutput("spill_done_once", cx_done_o, 0);

        // Fill with concurrent core writes to bank 0
        applyStimulus(2'd2, 2'd1);
        for (int i = 1; i <= 15; i++) begin
            checkOutput($sformatf("fill_ready_%0d", i), cx_fill_ready_o, 1);
            cx_fill_valid_i = 1'b1;
            cx_fill_data_i  = 32'hA0 + 32'(i);
            we_a_i    = 1'b1;
            waddr_a_i = 5'(16 + i);
            wdata_a_i = 32'hC000 + 32'(i);
            step();
        end
        cx_fill_valid_i = 1'b0;
        we_a_i = 1'b0;
        checkOutput("fill_done", cx_done_o, 1);
        checkOutput("fill_ready_end", cx_fill_ready_o, 0);
        for (int i = 17; i <= 31; i++)
            readCheck($sformatf("b0_core_x%0d", i), 5'(i), 32'hC000 + 32'(i - 16));
        readCheck("b0_x5_after_fill", 5'd5, 32'hDEADBEEF);
        applyStimulus(2'd0, 2'd1);
        for (int i = 1; i <= 15; i++)
            readCheck($sformatf("b1_fill_x%0d", i), 5'(i), 32'hA0 + 32'(i));
        readCheck("b1_x16_untouched", 5'd16, 32'h0);
        applyStimulus(2'd0, 2'd0);

        // Illegal commands
        applyStimulus(2'd1, 2'd0);
        checkOutput("ill_spill_active_err", err_o, 1);
        checkOutput("ill_spill_active_rdy", cx_cmd_ready_o, 1);
        checkOutput("ill_spill_active_valid", cx_spill_valid_o, 0);
        step();
        checkOutput("ill_err_pulse", err_o, 0);
        applyStimulus(2'd0, 2'd2);
        checkOutput("ill_bank2_err", err_o, 1);
        checkOutput("ill_bank2_active", active_bank_o, 0);
        applyStimulus(2'd3, 2'd1);
        checkOutput("ill_op3_err", err_o, 1);
        checkOutput("ill_op3_fill_ready", cx_fill_ready_o, 0);
        checkOutput("ill_op3_valid", cx_spill_valid_o, 0);
        applyStimulus(2'd0, 2'd0);
        checkOutput("switch_same_err", err_o, 0);
        checkOutput("switch_same_active", active_bank_o, 0);

        // Mid-transfer reset while spilling bank 0 from bank 1
        applyStimulus(2'd0, 2'd1);
        applyStimulus(2'd1, 2'd0);
        cx_spill_ready_i = 1'b1;
        repeat (7) step();
        checkOutput("midrst_idx_before", cx_spill_idx_o, 8);
        #2;
        rst_ni = 1'b0;
        cx_spill_ready_i = 1'b0;
        #1;
        checkOutput("midrst_valid", cx_spill_valid_o, 0);
        checkOutput("midrst_idx", cx_spill_idx_o, 0);
        checkOutput("midrst_data", cx_spill_data_o, 0);
        checkOutput("midrst_cmd_ready", cx_cmd_ready_o, 1);
        checkOutput("midrst_active", active_bank_o, 0);
        checkOutput("midrst_done", cx_done_o, 0);
        rst_ni = 1'b1;
        step();
        checkOutput("midrst_no_done", cx_done_o, 0);
        readCheck("midrst_b0_x5", 5'd5, 32'h0);
        applyStimulus(2'd1, 2'd1);
        checkOutput("respill_valid", cx_spill_valid_o, 1);
        checkOutput("respill_idx", cx_spill_idx_o, 1);
        checkOutput("respill_data", cx_spill_data_o, 32'h0);
        cx_spill_ready_i = 1'b1;
        repeat (15) step();
        cx_spill_ready_i = 1'b0;
        checkOutput("respill_done", cx_done_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
